// File: rtl/mux_sched_pkg.sv
// mux_sched_pkg: shared constants, FSM state type and one-hot helper for mux_rr_scheduler.
// Contents: N_REQ/SEL_W lane geometry, sched_state_t {IDLE, SERVE}, onehot16(idx).
package mux_sched_pkg;
   localparam int N_REQ = 16;
   localparam int SEL_W = 4;
   typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} sched_state_t;
   function automatic logic [N_REQ-1:0] onehot16(input logic [SEL_W-1:0] idx);
      return N_REQ'(1) << idx;
   endfunction
endpackage

// File: rtl/rr_pick16.sv
// rr_pick16: combinational round-robin search over 16 requests starting at ptr.
// Ports: req   - request vector
//        ptr   - lane with highest priority this search
//        found - any request present
//        idx   - first requesting lane at or after ptr (mod 16)
module rr_pick16
   import mux_sched_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic             found,
   output logic [SEL_W-1:0] idx
);
   logic [N_REQ-1:0] w_rot;
   logic [SEL_W-1:0] w_off;
   // rotate so ptr lands at bit 0, take lowest set bit, then add ptr back
   assign w_rot = N_REQ'({req, req} >> ptr);
   always_comb begin
      w_off = '0;
      for (int i = N_REQ - 1; i >= 0; i--)
         if (w_rot[i]) w_off = SEL_W'(i);
   end
   assign found = |req;
   assign idx   = ptr + w_off;
endmodule

// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler: round-robin scheduler sharing one 16:1 single-bit mux path with bounded bursts.
// Ports: clk, rst_n (sync, active low), en (gate for new grants), req[15:0], data_inputs[15:0],
//        out_ready -> out_valid, out_data (data_inputs[select_line]), select_line[3:0],
//        grant[15:0] (one-hot), busy (high while serving).
// Option: MUX_SCHED_LOCK_EN adds lock[15:0]; a locked grantee ignores the burst limit.
module mux_rr_scheduler
   import mux_sched_pkg::*;
#(
   parameter int MAX_BURST = 8,
   parameter int CNT_W     = 4
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] data_inputs,
`ifdef MUX_SCHED_LOCK_EN
   input  logic [N_REQ-1:0] lock,
`endif
   input  logic             out_ready,
   output logic             out_valid,
   output logic             out_data,
   output logic [SEL_W-1:0] select_line,
   output logic [N_REQ-1:0] grant,
   output logic             busy
);
   sched_state_t     r_state;
   logic [SEL_W-1:0] r_ptr;
   logic [SEL_W-1:0] r_sel;
   logic [N_REQ-1:0] r_grant;
   logic [CNT_W-1:0] r_cnt;
   logic             w_found;
   logic [SEL_W-1:0] w_idx;
   logic             w_serve;
   logic             w_req_sel;
   logic             w_lock;
   logic             w_xfer;
   logic             w_cnt_max;
   logic             w_exit;
   rr_pick16 u_pick (
      .req   (req),
      .ptr   (r_ptr),
      .found (w_found),
      .idx   (w_idx)
   );
`ifdef MUX_SCHED_LOCK_EN
   assign w_lock = lock[r_sel];
`else
   assign w_lock = 1'b0;
`endif
   assign w_serve   = r_state == SERVE;
   assign w_req_sel = req[r_sel];
   assign w_xfer    = out_valid & out_ready;
   assign w_cnt_max = r_cnt == CNT_W'(MAX_BURST - 1);
   // a dropped request and a final transfer can never coincide (valid needs req), so one exit term suffices
   assign w_exit    = w_serve & (~w_req_sel | (w_xfer & w_cnt_max & ~w_lock));
   assign out_valid   = w_serve & w_req_sel;
   assign out_data    = data_inputs[r_sel];
   assign select_line = r_sel;
   assign grant       = r_grant;
   assign busy        = w_serve;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_sel   <= '0;
         r_grant <= '0;
         r_cnt   <= '0;
      end else if (!w_serve) begin
         if (en && w_found) begin
            r_state <= SERVE;
            r_sel   <= w_idx;
            r_grant <= onehot16(w_idx);
            r_cnt   <= '0;
         end
      end else if (w_exit) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_ptr   <= r_sel + 1'b1;
      end else if (w_xfer && !w_cnt_max) begin
         // holding at the limit only happens under lock, giving saturation for free
         r_cnt <= r_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_mux_rr_scheduler.sv
// tb_mux_rr_scheduler: self-checking bench for mux_rr_scheduler against a transfer-counting reference model.
module tb_mux_rr_scheduler;
   localparam int MAXB = 8;
   logic        clk = 1'b0;
   logic        rst_n, en, out_ready;
   logic [15:0] req, data_inputs;
`ifdef MUX_SCHED_LOCK_EN
   logic [15:0] lock;
`endif
   logic        out_valid, out_data, busy;
   logic [3:0]  select_line;
   logic [15:0] grant;
   logic [22:0] act;
   int          tests = 0, fails = 0;
   int          m_serve, m_sel, m_ptr, m_cnt;
   always #5 clk = ~clk;
   mux_rr_scheduler dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .req         (req),
      .data_inputs (data_inputs),
`ifdef MUX_SCHED_LOCK_EN
      .lock        (lock),
`endif
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .select_line (select_line),
      .grant       (grant),
      .busy        (busy)
   );
   assign act = {busy, out_valid, out_data, select_line, grant};
   function automatic logic [22:0] exp_vec();
      logic [15:0] g;
      logic [3:0]  s;
      g = (m_serve != 0) ? (16'h1 << m_sel) : 16'h0;
      s = m_sel[3:0];
      return {(m_serve != 0), (m_serve != 0) && req[m_sel], data_inputs[m_sel], s, g};
   endfunction
   // model: search from pointer, count transfers per grant, leave on drop or on reaching the limit unlocked
   task automatic step();
      logic [15:0] lk;
      bit          hit;
      @(posedge clk);
`ifdef MUX_SCHED_LOCK_EN
      lk = lock;
`else
      lk = 16'h0;
`endif
      if (!rst_n) begin
         m_serve = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
      end else if (m_serve == 0) begin
         if (en && req != 16'h0) begin
            hit = 0;
            for (int k = 0; k < 16; k++)
               if (!hit && req[(m_ptr + k) % 16]) begin
                  m_sel = (m_ptr + k) % 16;
                  hit   = 1;
               end
            m_serve = 1;
            m_cnt   = 0;
         end
      end else if (!req[m_sel]) begin
         m_serve = 0; m_ptr = (m_sel + 1) % 16;
      end else if (out_ready) begin
         m_cnt++;
         if (m_cnt >= MAXB && !lk[m_sel]) begin
            m_serve = 0; m_ptr = (m_sel + 1) % 16;
         end
      end
      @(negedge clk);
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask
   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; req = 16'($urandom); out_ready = 1'b1; data_inputs = 16'($urandom);
`ifdef MUX_SCHED_LOCK_EN
      lock = 16'h0;
`endif
      step();
      step();
      data_inputs = 16'($urandom);
      #1;
      tests++;
      if ({busy, out_valid, select_line, grant} !== 22'h0) begin
         fails++; $display("FAIL reset_regs: got %h expected 0", {busy, out_valid, select_line, grant});
      end
      tests++;
      if (out_data !== data_inputs[0]) begin
         fails++; $display("FAIL reset_out_data: got %b expected %b", out_data, data_inputs[0]);
      end
      tests++;
      if (act !== exp_vec()) begin
         fails++; $display("FAIL reset_model: got %h expected %h", act, exp_vec());
      end
   endtask
   task automatic test_single_lane();
      int xf = 0;
      rst_n = 1'b1; en = 1'b1; out_ready = 1'b1; req = 16'h0020; data_inputs = 16'($urandom) | 16'h0020;
      step();
      #1;
      tests++;
      if (select_line !== 4'd5 || grant !== 16'h0020) begin
         fails++; $display("FAIL single_first_grant: got sel=%0d grant=%h expected sel=5 grant=0020", select_line, grant);
      end
      for (int c = 0; c < MAXB; c++) begin
         data_inputs = 16'($urandom) | 16'h0020;
         #1;
         tests++;
         if (act !== exp_vec()) begin
            fails++; $display("FAIL single_model: got %h expected %h", act, exp_vec());
         end
         if (out_valid && out_ready && out_data) xf++;
         step();
      end
      #1;
      tests++;
      if (xf !== MAXB || busy !== 1'b0) begin
         fails++; $display("FAIL single_burst: got xfers=%0d busy=%b expected xfers=8 busy=0", xf, busy);
      end
      step();
      #1;
      tests++;
      if (busy !== 1'b1 || grant !== 16'h0020) begin
         fails++; $display("FAIL single_regrant: got busy=%b grant=%h expected busy=1 grant=0020", busy, grant);
      end
      req = 16'h0;
      step();
   endtask
   task automatic test_rotation();
      int lanes[$];
      int nx[$];
      int dead[$];
      int xf = 0, gap = 0, bad = 0;
      bit prev = 0;
      do_reset();
      req = 16'hFFFF; en = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 160; c++) begin
         data_inputs = 16'($urandom);
         #1;
         tests++;
         if (act !== exp_vec()) begin
            fails++; $display("FAIL rotation_model: got %h expected %h", act, exp_vec());
         end
         if (busy) begin
            if (!prev) begin lanes.push_back(int'(select_line)); dead.push_back(gap); xf = 0; end
            if (out_valid && out_ready) xf++;
         end else begin
            if (prev) nx.push_back(xf);
            gap = prev ? 1 : gap + 1;
         end
         prev = busy;
         step();
      end
      if (lanes.size() < 17 || nx.size() < 17) bad++;
      else
         for (int i = 0; i < 17; i++) begin
            if (lanes[i] != i % 16) bad++;
            if (nx[i] != MAXB) bad++;
            if (i > 0 && dead[i] != 1) bad++;
         end
      tests++;
      if (bad != 0) begin
         fails++; $display("FAIL rotation_order: got %0d deviations in %0d grants expected 0", bad, lanes.size());
      end
   endtask
   task automatic test_wrap_skip();
      int lanes[$];
      bit prev = 0;
      do_reset();
      en = 1'b1; out_ready = 1'b1; req = 16'h2000;
      step();
      req = 16'h0;
      step();
      req = 16'h0009;
      for (int c = 0; c < 30; c++) begin
         data_inputs = 16'($urandom);
         #1;
         tests++;
         if (act !== exp_vec()) begin
            fails++; $display("FAIL wrap_model: got %h expected %h", act, exp_vec());
         end
         if (busy && !prev) lanes.push_back(int'(select_line));
         prev = busy;
         step();
      end
      tests++;
      if (lanes.size() < 3 || lanes[0] != 0 || lanes[1] != 3 || lanes[2] != 0) begin
         fails++; $display("FAIL wrap_order: got %0d grants first=%0d expected 0,3,0", lanes.size(), lanes.size() > 0 ? lanes[0] : -1);
      end
   endtask
   task automatic test_drop_backpressure();
      int xf = 0, p = 0;
      do_reset();
      en = 1'b1; out_ready = 1'b1; req = 16'h0280;
      step();
      for (int c = 0; c < 20 && xf < 3; c++) begin
         out_ready = (p % 4 == 0) || (p % 4 == 3);
         data_inputs = 16'($urandom);
         #1;
         tests++;
         if (act !== exp_vec()) begin
            fails++; $display("FAIL drop_model: got %h expected %h", act, exp_vec());
         end
         if (out_valid && out_ready) xf++;
         p++;
         step();
      end
      req = 16'h0208;
      out_ready = 1'b1;
      #1;
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
         fails++; $display("FAIL drop_valid: got valid=%b busy=%b expected valid=0 busy=1", out_valid, busy);
      end
      step();
      #1;
      tests++;
      if (busy !== 1'b0) begin
         fails++; $display("FAIL drop_exit: got busy=%b expected 0", busy);
      end
      step();
      #1;
      tests++;
      if (select_line !== 4'd9 || busy !== 1'b1) begin
         fails++; $display("FAIL drop_next: got sel=%0d busy=%b expected sel=9 busy=1", select_line, busy);
      end
   endtask
   task automatic test_simultaneous();
      do_reset();
      en = 1'b1; out_ready = 1'b1; req = 16'h0001;
      step();
      for (int c = 0; c < MAXB; c++) begin
         data_inputs = 16'($urandom);
         #1;
         tests++;
         if (act !== exp_vec()) begin
            fails++; $display("FAIL simul_model: got %h expected %h", act, exp_vec());
         end
         step();
      end
      req = 16'h0006;
      #1;
      tests++;
      if (busy !== 1'b0) begin
         fails++; $display("FAIL simul_exit: got busy=%b expected 0", busy);
      end
      step();
      #1;
      tests++;
      if (select_line !== 4'd1 || busy !== 1'b1) begin
         fails++; $display("FAIL simul_ptr: got sel=%0d busy=%b expected sel=1 busy=1", select_line, busy);
      end
   endtask
   task automatic test_enable();
      do_reset();
      en = 1'b0; out_ready = 1'b1; req = 16'hFFFF;
      step(); step(); step();
      #1;
      tests++;
      if (busy !== 1'b0 || grant !== 16'h0) begin
         fails++; $display("FAIL en_idle: got busy=%b grant=%h expected 0", busy, grant);
      end
      en = 1'b1;
      step();
      en = 1'b0;
      for (int c = 0; c < MAXB + 4; c++) begin
         data_inputs = 16'($urandom);
         #1;
         tests++;
         if (act !== exp_vec()) begin
            fails++; $display("FAIL en_model: got %h expected %h", act, exp_vec());
         end
         step();
      end
      #1;
      tests++;
      if (busy !== 1'b0) begin
         fails++; $display("FAIL en_hold: got busy=%b expected 0", busy);
      end
      en = 1'b1;
   endtask
`ifdef MUX_SCHED_LOCK_EN
   task automatic test_lock();
      int xf = 0;
      do_reset();
      en = 1'b1; out_ready = 1'b1; req = 16'h0024; lock = 16'h0004;
      step();
      for (int c = 0; c < 40; c++) begin
         if (xf == 20) lock = 16'h0;
         data_inputs = 16'($urandom);
         #1;
         tests++;
         if (act !== exp_vec()) begin
            fails++; $display("FAIL lock_model: got %h expected %h", act, exp_vec());
         end
         if (!busy) break;
         if (out_valid && out_ready && select_line == 4'd2) xf++;
         step();
      end
      tests++;
      if (xf != 21) begin
         fails++; $display("FAIL lock_len: got %0d transfers expected 21", xf);
      end
   endtask
`endif
   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rst_n = $urandom_range(0, 63) != 0;
         en = $urandom_range(0, 7) != 0;
         if ($urandom_range(0, 3) == 0) req = 16'($urandom) & 16'($urandom);
         out_ready = $urandom_range(0, 2) != 0;
         data_inputs = 16'($urandom);
`ifdef MUX_SCHED_LOCK_EN
         if ($urandom_range(0, 7) == 0) lock = 16'($urandom);
`endif
         #1;
         tests++;
         if (act !== exp_vec()) begin
            fails++; $display("FAIL random_model cycle %0d: got %h expected %h", c, act, exp_vec());
         end
         step();
      end
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
   initial begin
      m_serve = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
      test_reset();
      test_single_lane();
      test_rotation();
      test_wrap_skip();
      test_drop_backpressure();
      test_simultaneous();
      test_enable();
`ifdef MUX_SCHED_LOCK_EN
      test_lock();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
